fifo_wr_sched: RTL and testbench

Write-side scheduler for the system's asynchronous FIFO. It shares the FIFO write port between two requesters in the system clock domain: the ALU, which delivers a 16-bit result, and the register file, which delivers 8-bit read data. ALU results are serialized into two bytes, LSB first. The block arbitrates round-robin between the two requesters and never writes while the FIFO reports full.

---
 rtl/fifo_wr_sched_pkg.sv | 20 ++
 rtl/fifo_wr_slot.sv | 50 +++++
 rtl/fifo_wr_sched.sv | 137 +++++++++++++
 tb/tb_fifo_wr_sched.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_wr_sched_pkg.sv
// fifo_wr_sched_pkg: shared definitions for the FIFO write-side scheduler.
//   - DATA_WIDTH_DEF : default FIFO word width
//   - state_e        : scheduler FSM states with their fixed 2-bit encoding
package fifo_wr_sched_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 8;

    localparam logic [1:0] ST_IDLE_ENC   = 2'b00;
    localparam logic [1:0] ST_ALU_LO_ENC = 2'b01;
    localparam logic [1:0] ST_ALU_HI_ENC = 2'b10;
    localparam logic [1:0] ST_RF_B_ENC   = 2'b11;

    typedef enum logic [1:0] {
        StIdle  = ST_IDLE_ENC,
        StAluLo = ST_ALU_LO_ENC,
        StAluHi = ST_ALU_HI_ENC,
        StRfB   = ST_RF_B_ENC
    } state_e;

endpackage

// File: rtl/fifo_wr_slot.sv
// fifo_wr_slot: one request slot (pending bit + data register) of the write scheduler.
// Ports:
//   i_clk, i_rst  clock, asynchronous active-high reset
//   i_strobe      single-cycle request strobe, i_data sampled with it
//   i_done        the scheduler accepts this slot's final byte this cycle
//   o_pending     registered pending bit (drives the upstream BUSY)
//   o_data        captured request data
//   o_drop        registered pulse: a strobe hit an occupied slot and was discarded
module fifo_wr_slot
    import fifo_wr_sched_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_WIDTH_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_strobe,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_done,
    output logic             o_pending,
    output logic [WIDTH-1:0] o_data,
    output logic             o_drop
);

    logic             r_pending;
    logic [WIDTH-1:0] r_data;
    logic             r_drop;
    logic             w_accept;

    // A slot finishing its last byte this cycle is free for a same-cycle strobe.
    assign w_accept = i_strobe && (!r_pending || i_done);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pending <= 1'b0;
            r_data    <= '0;
            r_drop    <= 1'b0;
        end else begin
            r_pending <= w_accept || (r_pending && !i_done);
            if (w_accept) begin
                r_data <= i_data;
            end
            r_drop <= i_strobe && !w_accept;
        end
    end

    assign o_pending = r_pending;
    assign o_data    = r_data;
    assign o_drop    = r_drop;

endmodule

// File: rtl/fifo_wr_sched.sv
// fifo_wr_sched: shares the async FIFO write port between the ALU (2-byte results,
// LSB first) and the register file (1 byte), round-robin, never writing while full.
// Ports:
//   i_clk, i_rst    system clock, asynchronous active-high reset
//   i_alu_out       ALU result, sampled when i_alu_vld
//   i_alu_vld       single-cycle ALU strobe
//   i_rf_rd_data    register-file data, sampled when i_rf_rd_vld
//   i_rf_rd_vld     single-cycle register-file strobe
//   i_wr_full       FIFO full flag
//   o_wr_data       FIFO write data (0 when idle)
//   o_wr_inc        FIFO write enable
//   o_alu_busy      ALU slot occupied
//   o_rf_busy       register-file slot occupied
//   o_drop          one-cycle pulse when a strobe was discarded
module fifo_wr_sched
    import fifo_wr_sched_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [2*DATA_WIDTH-1:0] i_alu_out,
    input  logic                    i_alu_vld,
    input  logic [DATA_WIDTH-1:0]   i_rf_rd_data,
    input  logic                    i_rf_rd_vld,
    input  logic                    i_wr_full,
    output logic [DATA_WIDTH-1:0]   o_wr_data,
    output logic                    o_wr_inc,
    output logic                    o_alu_busy,
    output logic                    o_rf_busy,
    output logic                    o_drop
);

    state_e r_state;
    state_e w_state_next;
    logic   r_last_alu;     // 1: ALU was served last, 0: RF (reset value)
    logic   w_last_alu_next;

    logic                    w_wr_inc;
    logic                    w_alu_done;
    logic                    w_rf_done;
    logic                    w_alu_pend;
    logic                    w_rf_pend;
    logic [2*DATA_WIDTH-1:0] w_alu_data;
    logic [DATA_WIDTH-1:0]   w_rf_data;
    logic                    w_alu_drop;
    logic                    w_rf_drop;
    logic [DATA_WIDTH-1:0]   w_wr_data;

    fifo_wr_slot #(
        .WIDTH (2*DATA_WIDTH)
    ) u_alu_slot (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_strobe  (i_alu_vld),
        .i_data    (i_alu_out),
        .i_done    (w_alu_done),
        .o_pending (w_alu_pend),
        .o_data    (w_alu_data),
        .o_drop    (w_alu_drop)
    );

    fifo_wr_slot #(
        .WIDTH (DATA_WIDTH)
    ) u_rf_slot (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_strobe  (i_rf_rd_vld),
        .i_data    (i_rf_rd_data),
        .i_done    (w_rf_done),
        .o_pending (w_rf_pend),
        .o_data    (w_rf_data),
        .o_drop    (w_rf_drop)
    );

    // Every non-idle state presents a byte; it is written whenever the FIFO has room.
    assign w_wr_inc   = (r_state != StIdle) && !i_wr_full;
    assign w_alu_done = w_wr_inc && (r_state == StAluHi);
    assign w_rf_done  = w_wr_inc && (r_state == StRfB);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= StIdle;
            r_last_alu <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_last_alu <= w_last_alu_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_last_alu_next = r_last_alu;
        w_wr_data       = '0;
        unique case (r_state)
            StIdle: begin
                // On a tie the slot not served last wins.
                if (w_alu_pend && (!w_rf_pend || !r_last_alu)) begin
                    w_state_next = StAluLo;
                end else if (w_rf_pend) begin
                    w_state_next = StRfB;
                end
            end
            StAluLo: begin
                w_wr_data = w_alu_data[DATA_WIDTH-1:0];
                // Only ALU_HI may follow, so the two ALU bytes stay adjacent.
                if (w_wr_inc) begin
                    w_state_next = StAluHi;
                end
            end
            StAluHi: begin
                w_wr_data = w_alu_data[2*DATA_WIDTH-1:DATA_WIDTH];
                if (w_wr_inc) begin
                    w_state_next    = StIdle;
                    w_last_alu_next = 1'b1;
                end
            end
            StRfB: begin
                w_wr_data = w_rf_data;
                if (w_wr_inc) begin
                    w_state_next    = StIdle;
                    w_last_alu_next = 1'b0;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    assign o_wr_data  = w_wr_data;
    assign o_wr_inc   = w_wr_inc;
    assign o_alu_busy = w_alu_pend;
    assign o_rf_busy  = w_rf_pend;
    assign o_drop     = w_alu_drop || w_rf_drop;

endmodule

// File: tb/tb_fifo_wr_sched.sv
// tb_fifo_wr_sched: table vectors, directed multi-cycle sequences and a randomized run
// checked every cycle against a transaction-level model (pending slots + byte queue).
module tb_fifo_wr_sched;

    logic        clk;
    logic        i_rst;
    logic [15:0] i_alu_out;
    logic        i_alu_vld;
    logic [7:0]  i_rf_rd_data;
    logic        i_rf_rd_vld;
    logic        i_wr_full;
    logic [7:0]  o_wr_data;
    logic        o_wr_inc;
    logic        o_alu_busy;
    logic        o_rf_busy;
    logic        o_drop;

    fifo_wr_sched #(
        .DATA_WIDTH (8)
    ) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_alu_out    (i_alu_out),
        .i_alu_vld    (i_alu_vld),
        .i_rf_rd_data (i_rf_rd_data),
        .i_rf_rd_vld  (i_rf_rd_vld),
        .i_wr_full    (i_wr_full),
        .o_wr_data    (o_wr_data),
        .o_wr_inc     (o_wr_inc),
        .o_alu_busy   (o_alu_busy),
        .o_rf_busy    (o_rf_busy),
        .o_drop       (o_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_bad;
    logic [7:0] got[$];

    // Reference model: pending requests per slot, bytes of the transfer in progress.
    logic        m_alu_pend;
    logic        m_rf_pend;
    logic [15:0] m_alu_val;
    logic [7:0]  m_rf_val;
    logic        m_last_alu;
    logic        m_owner_alu;
    logic        m_drop;
    logic [7:0]  m_cur[$];

    typedef struct {
        logic        rst_first;
        logic        av;
        logic [15:0] ad;
        logic        rv;
        logic [7:0]  rd;
        logic        full;
        logic        e_inc;
        logic [7:0]  e_data;
        logic        e_ab;
        logic        e_rb;
        logic        e_drop;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t v(input logic r, input logic av, input logic [15:0] ad,
                               input logic rv, input logic [7:0] rd, input logic full,
                               input logic inc, input logic [7:0] data, input logic ab,
                               input logic rb, input logic drop);
        vec_t t;
        t.rst_first = r;   t.av = av;       t.ad = ad;     t.rv = rv;   t.rd = rd;
        t.full = full;     t.e_inc = inc;   t.e_data = data;
        t.e_ab = ab;       t.e_rb = rb;     t.e_drop = drop;
        return t;
    endfunction

    task automatic model_reset();
        m_alu_pend = 1'b0; m_rf_pend = 1'b0; m_alu_val = '0; m_rf_val = '0;
        m_last_alu = 1'b0; m_owner_alu = 1'b0; m_drop = 1'b0;
        m_cur.delete();
    endtask

    task automatic model_check();
        logic       e_inc;
        logic [7:0] e_data;
        e_inc  = (m_cur.size() != 0) && !i_wr_full;
        e_data = (m_cur.size() != 0) ? m_cur[0] : 8'h00;
        n_vec++;
        if (o_wr_inc !== e_inc || o_wr_data !== e_data || o_alu_busy !== m_alu_pend ||
            o_rf_busy !== m_rf_pend || o_drop !== m_drop) begin
            n_bad++;
            $display("FAIL model t=%0t: dut inc=%0b data=%02h ab=%0b rb=%0b drop=%0b, exp inc=%0b data=%02h ab=%0b rb=%0b drop=%0b",
                     $time, o_wr_inc, o_wr_data, o_alu_busy, o_rf_busy, o_drop,
                     e_inc, e_data, m_alu_pend, m_rf_pend, m_drop);
        end
    endtask

    task automatic model_update(input logic av, input logic [15:0] ad, input logic rv,
                                input logic [7:0] rd, input logic full);
        logic inc, last_byte, done_a, done_r, acc_a, acc_r;
        inc       = (m_cur.size() != 0) && !full;
        last_byte = inc && (m_cur.size() == 1);
        done_a    = last_byte && m_owner_alu;
        done_r    = last_byte && !m_owner_alu;
        acc_a     = av && (!m_alu_pend || done_a);
        acc_r     = rv && (!m_rf_pend || done_r);
        m_drop    = (av && !acc_a) || (rv && !acc_r);
        if (m_cur.size() == 0) begin
            if (m_alu_pend && (!m_rf_pend || !m_last_alu)) begin
                m_owner_alu = 1'b1;
                m_cur.push_back(m_alu_val[7:0]);
                m_cur.push_back(m_alu_val[15:8]);
            end else if (m_rf_pend) begin
                m_owner_alu = 1'b0;
                m_cur.push_back(m_rf_val);
            end
        end else if (inc) begin
            m_cur.delete(0);
            if (m_cur.size() == 0) m_last_alu = m_owner_alu;
        end
        m_alu_pend = acc_a || (m_alu_pend && !done_a);
        m_rf_pend  = acc_r || (m_rf_pend && !done_r);
        if (acc_a) m_alu_val = ad;
        if (acc_r) m_rf_val = rd;
    endtask

    task automatic drive(input logic av, input logic [15:0] ad, input logic rv,
                         input logic [7:0] rd, input logic full);
        i_alu_vld = av; i_alu_out = ad; i_rf_rd_vld = rv; i_rf_rd_data = rd;
        i_wr_full = full;
    endtask

    // One clock cycle: drive at the falling edge, sample 1 ns later, advance the model.
    task automatic step(input logic av, input logic [15:0] ad, input logic rv,
                        input logic [7:0] rd, input logic full);
        @(negedge clk);
        drive(av, ad, rv, rd, full);
        #1;
        model_check();
        if (o_wr_inc) got.push_back(o_wr_data);
        model_update(av, ad, rv, rd, full);
    endtask

    task automatic do_reset();
        @(negedge clk);
        i_rst = 1'b1;
        drive(1'b0, 16'h0, 1'b0, 8'h0, 1'b0);
        model_reset();
        @(negedge clk);
        i_rst = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_bytes(input string name, input logic [7:0] exp[$]);
        chk({name, " count"}, got.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            chk(name, (i < got.size()) ? {24'h0, got[i]} : 32'hFFFF_FFFF, {24'h0, exp[i]});
        end
    endtask

    task automatic wait_bytes(input int n, input int budget);
        int cnt;
        cnt = 0;
        while (got.size() < n && cnt < budget) begin
            step(1'b0, 16'h0, 1'b0, 8'h0, 1'b0);
            cnt++;
        end
        if (got.size() < n) chk("wait_bytes timeout", got.size(), n);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 16'h0, 1'b0, 8'h0, 1'b0);
    endtask

    initial begin
        logic [7:0] e[$];
        n_vec = 0;
        n_bad = 0;
        i_rst = 1'b1;
        drive(1'b0, 16'h0, 1'b0, 8'h0, 1'b0);
        model_reset();
        #1;
        chk("reset wr_inc", o_wr_inc, 0);
        chk("reset wr_data", o_wr_data, 0);
        chk("reset busy", {o_alu_busy, o_rf_busy, o_drop}, 0);

        //         rst   av    ad        rv    rd     full  inc   data   ab    rb    drop
        tbl[0]  = v(1'b1, 1'b1, 16'hA55A, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        tbl[1]  = v(1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        tbl[2]  = v(1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
        tbl[3]  = v(1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
        tbl[4]  = v(1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        tbl[5]  = v(1'b1, 1'b0, 16'h0000, 1'b1, 8'h01, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        tbl[6]  = v(1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        tbl[7]  = v(1'b0, 1'b0, 16'h0000, 1'b1, 8'h02, 1'b1, 1'b0, 8'h01, 1'b0, 1'b1, 1'b0);
        tbl[8]  = v(1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b1, 1'b1);
        tbl[9]  = v(1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0);
        tbl[10] = v(1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        tbl[11] = v(1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        tbl[12] = v(1'b1, 1'b0, 16'h0000, 1'b1, 8'h33, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        tbl[13] = v(1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        tbl[14] = v(1'b0, 1'b0, 16'h0000, 1'b1, 8'h44, 1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 1'b0);
        tbl[15] = v(1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        tbl[16] = v(1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b1, 8'h44, 1'b0, 1'b1, 1'b0);
        tbl[17] = v(1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 18; i++) begin
            if (tbl[i].rst_first) do_reset();
            step(tbl[i].av, tbl[i].ad, tbl[i].rv, tbl[i].rd, tbl[i].full);
            n_vec++;
            if (o_wr_inc !== tbl[i].e_inc || o_wr_data !== tbl[i].e_data ||
                o_alu_busy !== tbl[i].e_ab || o_rf_busy !== tbl[i].e_rb ||
                o_drop !== tbl[i].e_drop) begin
                n_bad++;
                $display("FAIL table[%0d]: dut inc=%0b data=%02h ab=%0b rb=%0b drop=%0b, exp inc=%0b data=%02h ab=%0b rb=%0b drop=%0b",
                         i, o_wr_inc, o_wr_data, o_alu_busy, o_rf_busy, o_drop,
                         tbl[i].e_inc, tbl[i].e_data, tbl[i].e_ab, tbl[i].e_rb,
                         tbl[i].e_drop);
            end
        end

        // Simultaneous requests: ALU wins the first tie, then alternation.
        do_reset();
        got.delete();
        step(1'b1, 16'h1234, 1'b1, 8'h77, 1'b0);
        wait_bytes(3, 20);
        e = '{8'h34, 8'h12, 8'h77};
        chk_bytes("pair1 order", e);
        idle(3);
        got.delete();
        step(1'b1, 16'h0F0F, 1'b0, 8'h00, 1'b0);
        wait_bytes(2, 20);
        idle(3);
        got.delete();
        step(1'b1, 16'hBEEF, 1'b1, 8'h11, 1'b0);
        wait_bytes(3, 20);
        e = '{8'h11, 8'hEF, 8'hBE};
        chk_bytes("pair2 round-robin", e);
        idle(3);

        // Stall between the two ALU bytes with an RF request waiting.
        do_reset();
        got.delete();
        step(1'b1, 16'hCAFE, 1'b0, 8'h00, 1'b0);
        step(1'b0, 16'h0000, 1'b0, 8'h00, 1'b0);
        step(1'b0, 16'h0000, 1'b1, 8'h99, 1'b0);
        repeat (5) step(1'b0, 16'h0000, 1'b0, 8'h00, 1'b1);
        chk("stall no writes", got.size(), 1);
        wait_bytes(3, 20);
        e = '{8'hFE, 8'hCA, 8'h99};
        chk_bytes("stall order", e);
        idle(3);

        // Reset in ALU_HI after the LSB went out.
        do_reset();
        got.delete();
        step(1'b1, 16'hA55A, 1'b0, 8'h00, 1'b0);
        idle(2);
        chk("pre-reset lsb", got.size(), 1);
        @(negedge clk);
        drive(1'b0, 16'h0, 1'b0, 8'h0, 1'b0);
        #1;
        model_check();
        i_rst = 1'b1;
        #1;
        chk("async rst wr_inc", o_wr_inc, 0);
        chk("async rst wr_data", o_wr_data, 0);
        chk("async rst busy", {o_alu_busy, o_rf_busy}, 0);
        chk("async rst drop", o_drop, 0);
        model_reset();
        @(negedge clk);
        i_rst = 1'b0;
        got.delete();
        step(1'b1, 16'h1234, 1'b0, 8'h00, 1'b0);
        wait_bytes(2, 20);
        e = '{8'h34, 8'h12};
        chk_bytes("post-reset lsb first", e);
        idle(3);

        // Randomized traffic, strobes deliberately ignore BUSY to exercise drops.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 3) == 0, 16'($urandom), $urandom_range(0, 3) == 0,
                     8'($urandom), $urandom_range(0, 2) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
